if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised fetch-to-decode pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the plain IF/ID flop. Adds a PC path, per-stage valid, back-pressure from decode, and a synchronous flush for branch/exception redirect.
- Sits between the instruction-memory response and the decoder.
- Sustains 1 instruction/cycle with a registered ready_f_o, so there is no combinational ready path from decode to fetch.

Parameters:
- DATA_W, 32, instruction width.
- PC_W, 32, program-counter width.
- NOP_INST, 32'h0000_0013, value presented on inst_d_o when the output is not valid.
- CNT_W, 16, stall counter width. Used only with the optional feature.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; drops all held instructions.
- inst_f_i  in  DATA_W  instruction from fetch.
- pc_f_i  in  PC_W  PC of inst_f_i.
- valid_f_i  in  1  fetch data valid.
- ready_f_o  out  1  block can accept; registered.
- inst_d_o  out  DATA_W  instruction to decode.
- pc_d_o  out  PC_W  PC to decode.
- valid_d_o  out  1  output valid.
- ready_d_i  in  1  decode accepts this cycle.
- stall_cnt_o  out  CNT_W  only with IF_ID_STALL_CNT_EN.

Behaviour:
- Reset (async, rst_i=1), all outputs:
  - valid_d_o=0, ready_f_o=1.
  - inst_d_o=NOP_INST, pc_d_o=0.
  - Skid entry invalid.
  - stall_cnt_o=0.
- Storage:
  - Main entry {m_v, m_inst, m_pc} drives the outputs.
  - Skid entry {s_v, s_inst, s_pc}.
- Output mapping:
  - valid_d_o = m_v.
  - inst_d_o = m_v ? m_inst : NOP_INST.
  - pc_d_o = m_v ? m_pc : 0.
- ready_f_o is a register equal to !s_v (next-state value).
- Handshake events:
  - Input accept: acc = valid_f_i & ready_f_o.
  - Output transfer: out = m_v & ready_d_i.
  - Data must stay stable while valid is high and ready is low, on both sides.
- Latency: an accepted instruction appears on the outputs the next cycle when main is empty or draining.
- Next-state rules, evaluated in priority order:
  1. flush_i=1: m_v=0 and s_v=0 next cycle. Any acc in the same cycle is discarded. ready_f_o=1 next cycle.
  2. Main empty, or out=1:
     - If s_v: main<=skid and s_v<=0. Any acc this cycle is impossible (ready_f_o=0).
     - Else if acc: main<=input.
     - Else: m_v<=0.
  3. Main full and out=0 (stall):
     - If acc: skid<=input, s_v<=1, ready_f_o<=0.
     - Main holds its value.
- Ordering is strict FIFO. No instruction is duplicated or dropped except by flush.
- Throughput: with ready_d_i=1 continuously, one instruction per cycle and the skid stays empty.
- Reset mid-operation: immediate clear of both entries to reset values, regardless of clock.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - stall_cnt_o port exists.
  - Counts cycles with m_v=1 and ready_d_i=0.
  - Saturates at all-ones; does not wrap.
  - Cleared by rst_i only; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INST default constant.
  - Default DATA_W and PC_W.
  - typedef if_id_t {inst, pc}, for reuse by the ID/EX and EX/MEM stage registers.
- One natural sub-module: pipe_skid_buf, a generic 2-entry valid/ready skid buffer parametrised on payload width. if_id_skid_reg wraps it, and adds NOP substitution, flush, and the counter.

Test Plan:
1. Reset check:
   - Stimulus: assert rst_i mid-stream while both entries are full.
   - Required, same cycle: valid_d_o=0, inst_d_o=32'h13, pc_d_o=0, ready_f_o=1.
2. Streaming:
   - Stimulus: ready_d_i=1; push inst 0xA0..0xA7 with PC 0x100..0x11C on consecutive cycles.
   - Required: each appears exactly one cycle later, in order; ready_f_o stays 1.
3. Stall and skid:
   - Stimulus: main holds 0xA0; drop ready_d_i for 3 cycles while 0xA1 is offered.
   - Required: 0xA1 goes to skid; ready_f_o=0 the next cycle; 0xA0 is held. On ready_d_i=1, output is 0xA0 then 0xA1, with no loss.
4. Flush precedence:
   - Stimulus: both entries full and valid_f_i=1 with 0xB0; assert flush_i for 1 cycle.
   - Required: next cycle valid_d_o=0, inst_d_o=NOP, ready_f_o=1; 0xB0 never appears.
5. Flush with stall:
   - Stimulus: flush_i and ready_d_i=0 in the same cycle.
   - Required: both entries cleared; no output transfer occurs.
6. Counter (IF_ID_STALL_CNT_EN, CNT_W=4):
   - Stimulus: hold a stall for 20 cycles.
   - Required: stall_cnt_o saturates at 15; a flush leaves it at 15; rst_i clears it to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default widths, the NOP encoding and the stage payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam int          PC_W_DEF     = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;   // addi x0, x0, 0

    // Instruction plus its PC, as carried between pipeline stage registers.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } if_id_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID stage register.
// Latency: n/a (wires only).
// Backpressure: ready_f_o toward fetch, ready_d_i from decode.
interface if_id_skid_reg_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) ();

    logic [DATA_W-1:0] inst_f_i;
    logic [PC_W-1:0]   pc_f_i;
    logic              valid_f_i;
    logic              ready_f_o;
    logic [DATA_W-1:0] inst_d_o;
    logic [PC_W-1:0]   pc_d_o;
    logic              valid_d_o;
    logic              ready_d_i;

    // The stage register itself.
    modport slave (
        input  inst_f_i, pc_f_i, valid_f_i, ready_d_i,
        output ready_f_o, inst_d_o, pc_d_o, valid_d_o
    );

    // Whoever drives fetch data and consumes decode data.
    modport master (
        output inst_f_i, pc_f_i, valid_f_i, ready_d_i,
        input  ready_f_o, inst_d_o, pc_d_o, valid_d_o
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main entry drives the output, skid catches one extra).
// Latency: 1 cycle from accept to output when main is empty or draining.
// Backpressure: in_rdy_o is registered (= skid empty next cycle); no comb path out_rdy_i -> in_rdy_o.
module pipe_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    output logic         in_rdy_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    input  logic         out_rdy_i
);

    logic         m_v_q, m_v_d, s_v_q, s_v_d, rdy_q, rdy_d;
    logic [W-1:0] m_q, m_d, s_q, s_d;
    logic         acc, xfer;

    assign acc  = in_vld_i & rdy_q;
    assign xfer = m_v_q & out_rdy_i;

    // Next state: flush wins, then refill main (skid first to keep order), else park input in skid.
    always_comb begin
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        m_d   = m_q;
        s_d   = s_q;
        if (flush_i) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q || xfer) begin
            if (s_v_q) begin
                m_d   = s_q;
                m_v_d = 1'b1;
                s_v_d = 1'b0;
            end else if (acc) begin
                m_d   = in_dat_i;
                m_v_d = 1'b1;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (acc) begin
            s_d   = in_dat_i;
            s_v_d = 1'b1;
        end
        rdy_d = !s_v_d;
    end

    // Entry storage and the registered ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
            rdy_q <= 1'b1;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
            rdy_q <= rdy_d;
            m_q   <= m_d;
            s_q   <= s_d;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_vld_o = m_v_q;
    assign out_dat_o = m_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register: skid-buffered {inst, pc} with NOP substitution, flush and optional stall counter.
// Latency: 1 cycle fetch -> decode; sustains 1 instr/cycle. Optional macro: IF_ID_STALL_CNT_EN.
// Backpressure: ready_f_o registered, drops only once the skid entry is occupied.
module if_id_skid_reg
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                PC_W     = PC_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF[DATA_W-1:0]
`ifdef IF_ID_STALL_CNT_EN
    ,
    parameter int                CNT_W    = 16
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    if_id_skid_reg_if.slave    bus
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o
`endif
);

    localparam int PW = DATA_W + PC_W;

    logic [PW-1:0] out_dat;
    logic          out_vld;

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .in_vld_i  (bus.valid_f_i),
        .in_dat_i  ({bus.inst_f_i, bus.pc_f_i}),
        .in_rdy_o  (bus.ready_f_o),
        .out_vld_o (out_vld),
        .out_dat_o (out_dat),
        .out_rdy_i (bus.ready_d_i)
    );

    // Decode sees a NOP and zero PC whenever nothing valid is held.
    assign bus.valid_d_o = out_vld;
    assign bus.inst_d_o  = out_vld ? out_dat[PW-1:PC_W] : NOP_INST;
    assign bus.pc_d_o    = out_vld ? out_dat[PC_W-1:0]  : '0;

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count decode stalls with a valid instruction waiting; saturate, survive flush.
    always_comb begin
        cnt_d = cnt_q;
        if (out_vld && !bus.ready_d_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Stall counter register, cleared by reset only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;
    import cpu_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;

    int errors = 0;
    int checks = 0;

    if_id_skid_reg_if #(.DATA_W(32), .PC_W(32)) bus ();

`ifdef IF_ID_STALL_CNT_EN
    logic [3:0] stall_cnt_o;
    if_id_skid_reg #(.DATA_W(32), .PC_W(32), .NOP_INST(NOP), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .bus(bus), .stall_cnt_o(stall_cnt_o));
`else
    if_id_skid_reg #(.DATA_W(32), .PC_W(32), .NOP_INST(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .bus(bus));
`endif

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        vf;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rd;
        logic        fl;
        logic        ev;
        if_id_t      eo;
        logic        er;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vf, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rd, input logic fl,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic er);
        vec_t v;
        v.vf = vf; v.inst = inst; v.pc = pc; v.rd = rd; v.fl = fl;
        v.ev = ev; v.eo.inst = ei; v.eo.pc = ep; v.er = er;
        tv.push_back(v);
    endtask

    task automatic drive(input logic vf, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rd, input logic fl);
        bus.valid_f_i = vf;
        bus.inst_f_i  = inst;
        bus.pc_f_i    = pc;
        bus.ready_d_i = rd;
        flush_i       = fl;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic er);
        chk({tag, ".valid_d"}, 64'(bus.valid_d_o), 64'(ev));
        chk({tag, ".inst_d"},  64'(bus.inst_d_o),  64'(ei));
        chk({tag, ".pc_d"},    64'(bus.pc_d_o),    64'(ep));
        chk({tag, ".ready_f"}, 64'(bus.ready_f_o), 64'(er));
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // streaming A0..A7, then idle
        for (int i = 0; i < 8; i++)
            add(1, 32'hA0 + i, 32'h100 + 4 * i, 1, 0, 1, 32'hA0 + i, 32'h100 + 4 * i, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);
        // stall and skid: A1 parked, A2 held off while ready_f_o=0
        add(1, 32'hA0, 32'h100, 1, 0, 1, 32'hA0, 32'h100, 1);
        add(1, 32'hA1, 32'h104, 0, 0, 1, 32'hA0, 32'h100, 0);
        add(1, 32'hA2, 32'h108, 0, 0, 1, 32'hA0, 32'h100, 0);
        add(1, 32'hA2, 32'h108, 0, 0, 1, 32'hA0, 32'h100, 0);
        add(1, 32'hA2, 32'h108, 1, 0, 1, 32'hA1, 32'h104, 1);
        add(1, 32'hA2, 32'h108, 1, 0, 1, 32'hA2, 32'h108, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);
        // flush with both entries full, decode ready, B0 offered
        add(1, 32'hC0, 32'h200, 1, 0, 1, 32'hC0, 32'h200, 1);
        add(1, 32'hC1, 32'h204, 0, 0, 1, 32'hC0, 32'h200, 0);
        add(1, 32'hB0, 32'h300, 1, 1, 0, NOP, 0, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);
        // flush while an input is actually accepted and decode stalls: B1 discarded
        add(1, 32'hC2, 32'h208, 1, 0, 1, 32'hC2, 32'h208, 1);
        add(1, 32'hB1, 32'h304, 0, 1, 0, NOP, 0, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);
        // flush with stall, both full; afterwards a fresh instruction is clean
        add(1, 32'hD0, 32'h400, 1, 0, 1, 32'hD0, 32'h400, 1);
        add(1, 32'hD1, 32'h404, 0, 0, 1, 32'hD0, 32'h400, 0);
        add(1, 32'hD2, 32'h408, 0, 1, 0, NOP, 0, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);
        add(1, 32'hD3, 32'h40C, 1, 0, 1, 32'hD3, 32'h40C, 1);
        add(0, 0, 0, 1, 0, 0, NOP, 0, 1);

        #2;
        chk_out("reset", 1'b0, NOP, 32'h0, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
        chk("reset.stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].vf, tv[i].inst, tv[i].pc, tv[i].rd, tv[i].fl);
            @(posedge clk_i);
            #1;
            chk_out($sformatf("vec%0d", i), tv[i].ev, tv[i].eo.inst, tv[i].eo.pc, tv[i].er);
        end

        // asynchronous reset mid-stream with both entries full
        drive(1'b1, 32'hE0, 32'h500, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b1, 32'hE1, 32'h504, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        chk_out("prefill", 1'b1, 32'hE0, 32'h500, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, NOP, 32'h0, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        chk_out("post_rst", 1'b0, NOP, 32'h0, 1'b1);

`ifdef IF_ID_STALL_CNT_EN
        drive(1'b1, 32'hF0, 32'h600, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        chk("cnt.start", 64'(stall_cnt_o), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        chk("cnt.five", 64'(stall_cnt_o), 64'd5);
        repeat (15) @(posedge clk_i);
        #1;
        chk("cnt.sat", 64'(stall_cnt_o), 64'd15);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("cnt.flush", 64'(stall_cnt_o), 64'd15);
        chk("cnt.flush_valid", 64'(bus.valid_d_o), 64'd0);
        rst_i = 1'b1;
        #1;
        chk("cnt.rst", 64'(stall_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
